id_ex_stage: RTL and testbench



---
 rtl/id_ex_stage_pkg.sv | 52 +++++
 rtl/id_ex_stage_imm_gen.sv | 21 ++
 rtl/id_ex_stage.sv | 193 +++++++++++++++++++
 tb/tb_id_ex_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared opcodes, ALU op codes and control bundle for decode/execute
package id_ex_stage_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // alt selects SUB/SRA; the caller decides when instr[30] is meaningful
    function automatic logic [3:0] alu_op_from_funct3(input logic [2:0] funct3, input logic alt);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_ex_stage_imm_gen.sv
// rtl/id_ex_stage_imm_gen.sv - combinational sign-extended immediate generator selected by opcode
module imm_gen
    import id_ex_stage_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    always_comb begin
        imm = 32'd0;
        case (instr[6:0])
            OP_IMM,
            OP_LOAD:   imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI:    imm = {instr[31:12], 12'd0};
            default:   imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - RV32I decode with write-back bypass and ID/EX pipeline register
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        flush,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs1_data,
    output logic [31:0] ex_rs2_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic [3:0]  ex_alu_op,
    output logic        ex_alu_src,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_mem_to_reg,
    output logic        ex_branch,
    output logic        ex_illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] dec_imm;
    ctrl_t       dec_ctrl;
    logic        use_rs1, use_rs2, use_rd;
    logic [31:0] byp1, byp2;
    logic        wb_hit_ok;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    imm_gen u_imm_gen (
        .instr (instr),
        .imm   (dec_imm)
    );

    always_comb begin
        dec_ctrl = CTRL_NOP;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        use_rd   = 1'b0;
        case (opcode)
            OP_R: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_op    = alu_op_from_funct3(funct3, instr[30]);
                {use_rs1, use_rs2, use_rd} = 3'b111;
            end
            OP_IMM: begin
                // instr[30] is immediate data except for SRAI
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_op    = alu_op_from_funct3(funct3, instr[30] && (funct3 == 3'b101));
                {use_rs1, use_rs2, use_rd} = 3'b101;
            end
            OP_LOAD: begin
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
                {use_rs1, use_rs2, use_rd} = 3'b101;
            end
            OP_STORE: begin
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.mem_write = 1'b1;
                {use_rs1, use_rs2, use_rd} = 3'b110;
            end
            OP_BRANCH: begin
                dec_ctrl.branch = 1'b1;
                dec_ctrl.alu_op = ALU_SUB;
                {use_rs1, use_rs2, use_rd} = 3'b110;
            end
            OP_LUI: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.alu_op    = ALU_PASSB;
                use_rd             = 1'b1;
            end
            default: dec_ctrl.illegal = 1'b1;
        endcase
    end

    // Register file writes on the edge, so a same-cycle write-back must be forwarded
    assign wb_hit_ok = wb_we && (wb_rd != 5'd0);
    assign byp1 = (wb_hit_ok && (wb_rd == rs1)) ? wb_data : rf_rdata1;
    assign byp2 = (wb_hit_ok && (wb_rd == rs2)) ? wb_data : rf_rdata2;

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] d1_q, d1_d;
    logic [31:0] d2_q, d2_d;
    logic [31:0] imm_q, imm_d;
    logic [4:0]  rs1_q, rs1_d;
    logic [4:0]  rs2_q, rs2_d;
    logic [4:0]  rd_q, rd_d;
    ctrl_t       ctrl_q, ctrl_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        imm_d   = imm_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        if (flush || (!stall && !in_valid)) begin
            valid_d = 1'b0;
            pc_d    = 32'd0;
            d1_d    = 32'd0;
            d2_d    = 32'd0;
            imm_d   = 32'd0;
            rs1_d   = 5'd0;
            rs2_d   = 5'd0;
            rd_d    = 5'd0;
            ctrl_d  = CTRL_NOP;
        end else if (stall) begin
            // A held instruction must still see registers written back while it waits
            if (valid_q && wb_hit_ok && (wb_rd == rs1_q)) d1_d = wb_data;
            if (valid_q && wb_hit_ok && (wb_rd == rs2_q)) d2_d = wb_data;
        end else begin
            valid_d = 1'b1;
            pc_d    = pc;
            d1_d    = byp1;
            d2_d    = byp2;
            imm_d   = dec_imm;
            rs1_d   = use_rs1 ? rs1 : 5'd0;
            rs2_d   = use_rs2 ? rs2 : 5'd0;
            rd_d    = use_rd ? instr[11:7] : 5'd0;
            ctrl_d  = dec_ctrl;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            pc_q    <= 32'd0;
            d1_q    <= 32'd0;
            d2_q    <= 32'd0;
            imm_q   <= 32'd0;
            rs1_q   <= 5'd0;
            rs2_q   <= 5'd0;
            rd_q    <= 5'd0;
            ctrl_q  <= CTRL_NOP;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            imm_q   <= imm_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_pc         = pc_q;
    assign ex_rs1_data   = d1_q;
    assign ex_rs2_data   = d2_q;
    assign ex_imm        = imm_q;
    assign ex_rs1        = rs1_q;
    assign ex_rs2        = rs2_q;
    assign ex_rd         = rd_q;
    assign ex_alu_op     = ctrl_q.alu_op;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_branch     = ctrl_q.branch;
    assign ex_illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized scoreboard bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [31:0] instr = 32'd0, pc = 32'd0, rf_rdata1 = 32'd0, rf_rdata2 = 32'd0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [31:0] wb_data = 32'd0;
    logic [4:0]  rs1, rs2, ex_rs1, ex_rs2, ex_rd;
    logic        ex_valid, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write;
    logic        ex_mem_to_reg, ex_branch, ex_illegal;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [3:0]  ex_alu_op;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr), .pc(pc),
        .stall(stall), .flush(flush), .rs1(rs1), .rs2(rs2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_branch(ex_branch), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  op;
        logic        src, rw, mr, mw, m2r, br, ill;
    } exp_t;

    exp_t m;
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic exp_t dut_now();
        return '{ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
                 ex_alu_op, ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write,
                 ex_mem_to_reg, ex_branch, ex_illegal};
    endfunction

    // Reference decode written from the instruction-set rules
    function automatic exp_t decode(input logic [31:0] i, input logic [31:0] p,
                                    input logic [31:0] a, input logic [31:0] b);
        exp_t e = '0;
        int   r_ops[8] = '{0, 5, 8, 9, 4, 6, 3, 2};
        logic [12:0] bimm;
        logic [11:0] simm;
        int   f3 = int'(i[14:12]);
        e.valid = 1'b1; e.pc = p; e.d1 = a; e.d2 = b;
        case (i[6:0])
            7'b0110011: begin
                e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7]; e.rw = 1;
                e.op = 4'(r_ops[f3]);
                if (i[30] && f3 == 0) e.op = 4'd1;
                if (i[30] && f3 == 5) e.op = 4'd7;
            end
            7'b0010011: begin
                e.rs1 = i[19:15]; e.rd = i[11:7]; e.rw = 1; e.src = 1;
                e.imm = 32'($signed(i) >>> 20);
                e.op = 4'(r_ops[f3]);
                if (i[30] && f3 == 5) e.op = 4'd7;
            end
            7'b0000011: begin
                e.rs1 = i[19:15]; e.rd = i[11:7]; e.rw = 1; e.src = 1; e.mr = 1; e.m2r = 1;
                e.imm = 32'($signed(i) >>> 20);
            end
            7'b0100011: begin
                e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.src = 1; e.mw = 1;
                simm = {i[31:25], i[11:7]};
                e.imm = 32'(int'($signed(simm)));
            end
            7'b1100011: begin
                e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.br = 1; e.op = 4'd1;
                bimm = {i[31], i[7], i[30:25], i[11:8], 1'b0};
                e.imm = 32'(int'($signed(bimm)));
            end
            7'b0110111: begin
                e.rd = i[11:7]; e.rw = 1; e.src = 1; e.op = 4'd10;
                e.imm = i & 32'hFFFF_F000;
            end
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    function automatic exp_t model_next(input exp_t cur);
        exp_t n = cur;
        logic [31:0] a, b;
        if (flush) return '0;
        if (stall) begin
            if (cur.valid && wb_we && wb_rd != 0 && wb_rd == cur.rs1) n.d1 = wb_data;
            if (cur.valid && wb_we && wb_rd != 0 && wb_rd == cur.rs2) n.d2 = wb_data;
            return n;
        end
        if (!in_valid) return '0;
        a = (wb_we && wb_rd != 0 && wb_rd == instr[19:15]) ? wb_data : rf_rdata1;
        b = (wb_we && wb_rd != 0 && wb_rd == instr[24:20]) ? wb_data : rf_rdata2;
        return decode(instr, pc, a, b);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Monitor: every cycle the EX register presents a state, compare it with the oldest prediction
    always @(negedge clk) begin
        exp_t e, a;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = dut_now();
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL ex_state: got %h expected %h", a, e);
            end
        end
    end

    // Called just after a falling edge; returns at the next falling edge
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                        input logic st, input logic fl, input logic [31:0] r1,
                        input logic [31:0] r2, input logic we, input logic [4:0] wrd,
                        input logic [31:0] wd);
        exp_t nxt;
        in_valid = v; instr = ins; pc = p; stall = st; flush = fl;
        rf_rdata1 = r1; rf_rdata2 = r2; wb_we = we; wb_rd = wrd; wb_data = wd;
        #1;
        chk("rs1_comb", 32'(rs1), 32'(ins[19:15]));
        chk("rs2_comb", 32'(rs2), 32'(ins[24:20]));
        nxt = model_next(m);
        @(posedge clk);
        #1;
        m = nxt;
        exp_q.push_back(nxt);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        logic [6:0]  ops[7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                               7'b1100011, 7'b0110111, 7'b1111111};
        r[19:15] = 5'($urandom_range(0, 3));
        r[24:20] = 5'($urandom_range(0, 3));
        r[11:7]  = 5'($urandom_range(0, 3));
        r[6:0]   = ops[$urandom_range(0, 6)];
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m = '0;
        #1;
        chk("reset_valid", 32'(ex_valid), 32'd0);
        chk("reset_alu_op", 32'(ex_alu_op), 32'd0);
        chk("reset_state", dut_now() == exp_t'(0) ? 32'd1 : 32'd0, 32'd1);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;

        // ADDI x5,x1,-3
        step(1, 32'hFFD0_8293, 32'h100, 0, 0, 32'd10, 32'd77, 0, 5'd0, 32'd0);
        chk("addi_imm", ex_imm, 32'hFFFF_FFFD);
        chk("addi_rd", 32'(ex_rd), 32'd5);
        chk("addi_rs2", 32'(ex_rs2), 32'd0);
        chk("addi_ctl", {30'd0, ex_alu_src, ex_reg_write}, 32'd3);
        chk("addi_d1", ex_rs1_data, 32'd10);

        // ADD x3,x1,x2 with and without a matching write-back
        step(1, 32'h0020_81B3, 32'h104, 0, 0, 32'h11, 32'h22, 1, 5'd1, 32'h55);
        chk("byp_hit", ex_rs1_data, 32'h55);
        step(1, 32'h0020_81B3, 32'h108, 0, 0, 32'h11, 32'h22, 1, 5'd0, 32'h55);
        chk("byp_x0", ex_rs1_data, 32'h11);

        // SW x2,8(x1) held two cycles while x2 is written back
        step(1, 32'h0020_A423, 32'h10C, 0, 0, 32'h1000, 32'h1, 0, 5'd0, 32'd0);
        step(1, 32'h0000_0013, 32'h110, 1, 0, 32'd0, 32'd0, 1, 5'd2, 32'hABCD);
        step(1, 32'h0000_0013, 32'h114, 1, 0, 32'd0, 32'd0, 0, 5'd2, 32'h9999);
        chk("stall_d2", ex_rs2_data, 32'hABCD);
        chk("stall_d1", ex_rs1_data, 32'h1000);
        chk("stall_rd", 32'(ex_rd), 32'd0);
        chk("stall_pc", ex_pc, 32'h10C);
        chk("stall_imm", ex_imm, 32'd8);

        step(1, 32'h0000_0013, 32'h118, 1, 1, 32'd0, 32'd0, 0, 5'd0, 32'd0);
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_ctl", {25'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                          ex_branch, ex_alu_src, ex_illegal}, 32'd0);

        step(1, 32'h0000_007F, 32'h11C, 0, 0, 32'd0, 32'd0, 0, 5'd0, 32'd0);
        chk("ill_flags", {29'd0, ex_valid, ex_illegal, ex_reg_write}, 32'd6);
        chk("ill_mw_br", {30'd0, ex_mem_write, ex_branch}, 32'd0);

        // LW x5,0(x1) held by stall, then reset asserted between edges
        step(1, 32'h0000_A283, 32'h120, 0, 0, 32'h40, 32'd0, 0, 5'd0, 32'd0);
        step(1, 32'h0000_0013, 32'h124, 1, 0, 32'd0, 32'd0, 0, 5'd0, 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("async_reset", dut_now() == exp_t'(0) ? 32'd1 : 32'd0, 32'd1);
        chk("async_valid", 32'(ex_valid), 32'd0);
        m = '0;
        @(negedge clk);
        reset = 1'b1;
        step(1, 32'h0000_A283, 32'h128, 0, 0, 32'h44, 32'd0, 0, 5'd0, 32'd0);
        chk("post_reset_mr", 32'(ex_mem_read), 32'd1);
        chk("post_reset_pc", ex_pc, 32'h128);

        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 99) < 85), rand_instr(), $urandom,
                 ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 8),
                 $urandom, $urandom, ($urandom_range(0, 99) < 60),
                 5'($urandom_range(0, 3)), $urandom);
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
